breakout_brickfield: RTL and testbench

Parametrised brick-wall engine for the Breakout VGA game. It replaces the fixed per-row brick instances with a single N_ROWS x N_COLS alive bitmap, a sequential once-per-frame ball/brick collision scanner, a taken-brick counter and a registered pixel renderer. It sits beside the bar and ball animators and feeds the top-level priority mux. Its hit and bounce-side outputs drive the ball animator.

---
 rtl/breakout_brickfield.sv | 193 +++++++++++++++++++
 tb/tb_breakout_brickfield.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/breakout_brickfield.sv
// Breakout brick wall: alive bitmap, once-per-frame ball/brick collision scan,
// taken-brick counter and a registered pixel renderer.
module breakout_brickfield #(
  parameter int unsigned N_ROWS         = 4,
  parameter int unsigned N_COLS         = 10,
  parameter int unsigned X_OFFSET       = 0,
  parameter int unsigned Y_OFFSET       = 32,
  parameter int unsigned COL_PITCH_LOG2 = 6,
  parameter int unsigned ROW_PITCH_LOG2 = 4,
  parameter int unsigned BRICK_W        = 60,
  parameter int unsigned BRICK_H        = 12,
  parameter int unsigned BALL_SIZE      = 8,
  parameter logic [23:0] ROW_PALETTE    = 24'o01234567,
  localparam int unsigned CNT_W         = $clog2(N_ROWS*N_COLS+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_on,
  input  logic             tick60hz,
  input  logic             new_game,
  input  logic             freeze,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic [9:0]       ball_x_l,
  input  logic [9:0]       ball_y_t,
  output logic             brick_on,
  output logic [2:0]       brick_rgb,
  output logic             hit,
  output logic [1:0]       hit_side,
  output logic [CNT_W-1:0] bricks_taken,
  output logic             all_cleared,
  output logic             scan_busy
);

  localparam int unsigned N     = N_ROWS * N_COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned GW    = 16;

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_CLEAR} state_e;

  state_e           state, next_state;
  logic [N-1:0]     alive;
  logic [9:0]       bx, by;
  logic [IDX_W-1:0] scan_idx;
  logic [COL_W-1:0] scan_col;
  logic [ROW_W-1:0] scan_row;

  logic [GW-1:0] x0, x1, y0, y1, bx_l, bx_r, by_t, by_b, bx_c;
  logic          overlap_c, center_in_c, last_idx_c, last_brick_c;
  logic          start_scan_c, hit_c, advance_c;
  logic [1:0]    side_c;

  // Geometry of the brick currently under test against the latched ball box
  always_comb begin
    x0   = GW'(X_OFFSET) + (GW'(scan_col) << COL_PITCH_LOG2);
    y0   = GW'(Y_OFFSET) + (GW'(scan_row) << ROW_PITCH_LOG2);
    x1   = x0 + GW'(BRICK_W - 1);
    y1   = y0 + GW'(BRICK_H - 1);
    bx_l = GW'(bx);
    by_t = GW'(by);
    bx_r = bx_l + GW'(BALL_SIZE - 1);
    by_b = by_t + GW'(BALL_SIZE - 1);
    bx_c = bx_l + GW'(BALL_SIZE / 2);
    overlap_c    = alive[scan_idx] && (bx_l <= x1) && (bx_r >= x0)
                   && (by_t <= y1) && (by_b >= y0);
    center_in_c  = (bx_c >= x0) && (bx_c <= x1);
    last_idx_c   = (scan_idx == IDX_W'(N - 1));
    last_brick_c = (bricks_taken == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (new_game) begin
      next_state = S_WAIT;
    end else begin
      case (state)
        S_WAIT:  if (tick60hz && !freeze) next_state = S_SCAN;
        S_SCAN: begin
          if (freeze)          next_state = S_WAIT;
          else if (overlap_c)  next_state = last_brick_c ? S_CLEAR : S_WAIT;
          else if (last_idx_c) next_state = S_WAIT;
        end
        S_CLEAR: next_state = S_CLEAR;
        default: next_state = S_WAIT;
      endcase
    end
  end

  // Per-cycle control strobes; new_game and freeze pre-empt any scan activity
  always_comb begin
    start_scan_c = 1'b0;
    hit_c        = 1'b0;
    advance_c    = 1'b0;
    side_c       = center_in_c ? 2'b01 : 2'b10;
    if (!new_game) begin
      case (state)
        S_WAIT: start_scan_c = tick60hz && !freeze;
        S_SCAN: begin
          hit_c     = !freeze && overlap_c;
          advance_c = !freeze && !overlap_c && !last_idx_c;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive        <= '1;
      bx           <= '0;
      by           <= '0;
      scan_idx     <= '0;
      scan_col     <= '0;
      scan_row     <= '0;
      hit          <= 1'b0;
      hit_side     <= 2'b00;
      bricks_taken <= '0;
      all_cleared  <= 1'b0;
      scan_busy    <= 1'b0;
    end else begin
      hit         <= hit_c;
      all_cleared <= (next_state == S_CLEAR);
      scan_busy   <= (next_state == S_SCAN);
      if (new_game) begin
        alive        <= '1;
        hit_side     <= 2'b00;
        bricks_taken <= '0;
      end else if (hit_c) begin
        alive[scan_idx] <= 1'b0;
        hit_side        <= side_c;
        if (bricks_taken < CNT_W'(N)) bricks_taken <= bricks_taken + CNT_W'(1);
      end else if (start_scan_c) begin
        hit_side <= 2'b00;
      end
      if (start_scan_c) begin
        bx       <= ball_x_l;
        by       <= ball_y_t;
        scan_idx <= '0;
        scan_col <= '0;
        scan_row <= '0;
      end else if (advance_c) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (scan_col == COL_W'(N_COLS - 1)) begin
          scan_col <= '0;
          scan_row <= scan_row + ROW_W'(1);
        end else begin
          scan_col <= scan_col + COL_W'(1);
        end
      end
    end
  end

  // Renderer: locate the pixel in the brick grid; a borrow means left/above the wall
  logic [GW-1:0]    rel_x, rel_y, pcol, prow, pidx_w;
  logic [IDX_W-1:0] pidx;
  logic             in_grid, pix_on_c;
  logic [4:0]       pal_lsb;
  logic [2:0]       pal_c;

  always_comb begin
    rel_x   = GW'(pix_x) - GW'(X_OFFSET);
    rel_y   = GW'(pix_y) - GW'(Y_OFFSET);
    pcol    = rel_x >> COL_PITCH_LOG2;
    prow    = rel_y >> ROW_PITCH_LOG2;
    in_grid = !rel_x[GW-1] && !rel_y[GW-1]
              && (pcol < GW'(N_COLS)) && (prow < GW'(N_ROWS))
              && (GW'(rel_x[COL_PITCH_LOG2-1:0]) < GW'(BRICK_W))
              && (GW'(rel_y[ROW_PITCH_LOG2-1:0]) < GW'(BRICK_H));
    pidx_w   = prow * GW'(N_COLS) + pcol;
    pidx     = in_grid ? IDX_W'(pidx_w) : '0;
    pix_on_c = video_on && in_grid && alive[pidx];
    pal_lsb  = 5'(3 * prow[2:0]);
    pal_c    = ROW_PALETTE[pal_lsb +: 3];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brick_on  <= 1'b0;
      brick_rgb <= 3'b000;
    end else begin
      brick_on  <= pix_on_c;
      brick_rgb <= pix_on_c ? pal_c : 3'b000;
    end
  end

endmodule

// File: tb/tb_breakout_brickfield.sv
// Directed bench: default 4x10 wall plus a 1x2 wall for the clear-all and reset cases.
module tb_breakout_brickfield;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       video_on;
  logic [9:0] pix_x, pix_y;

  logic       reset, tick, new_game, freeze;
  logic [9:0] ball_x, ball_y;
  logic       brick_on, hit, all_cleared, scan_busy;
  logic [2:0] brick_rgb;
  logic [1:0] hit_side;
  logic [5:0] bricks_taken;

  logic       reset2, tick2, new_game2, freeze2;
  logic [9:0] ball_x2, ball_y2;
  logic       brick_on2, hit2, all_cleared2, scan_busy2;
  logic [2:0] brick_rgb2;
  logic [1:0] hit_side2;
  logic [1:0] bricks_taken2;

  int errors = 0;
  int checks = 0;

  breakout_brickfield dut (
    .clk(clk), .reset(reset), .video_on(video_on), .tick60hz(tick),
    .new_game(new_game), .freeze(freeze), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x), .ball_y_t(ball_y), .brick_on(brick_on),
    .brick_rgb(brick_rgb), .hit(hit), .hit_side(hit_side),
    .bricks_taken(bricks_taken), .all_cleared(all_cleared), .scan_busy(scan_busy)
  );

  breakout_brickfield #(.N_ROWS(1), .N_COLS(2)) dut2 (
    .clk(clk), .reset(reset2), .video_on(video_on), .tick60hz(tick2),
    .new_game(new_game2), .freeze(freeze2), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x2), .ball_y_t(ball_y2), .brick_on(brick_on2),
    .brick_rgb(brick_rgb2), .hit(hit2), .hit_side(hit_side2),
    .bricks_taken(bricks_taken2), .all_cleared(all_cleared2), .scan_busy(scan_busy2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic render(input int x, input int y, input bit von);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = von;
    step();
  endtask

  // Pulse a tick on one wall and watch it for a bounded number of cycles
  task automatic run_scan(input bit sel, input int max_cyc,
                          output int hit_at, output int busy, output int nhit);
    if (sel) tick2 = 1'b1; else tick = 1'b1;
    hit_at = -1;
    busy   = 0;
    nhit   = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      tick  = 1'b0;
      tick2 = 1'b0;
      if (sel ? hit2 : hit) begin
        nhit++;
        if (hit_at < 0) hit_at = i;
      end
      busy += int'(sel ? scan_busy2 : scan_busy);
    end
  endtask

  int hit_at, busy, nhit;

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    tick = 1'b0; tick2 = 1'b0; new_game = 1'b0; new_game2 = 1'b0;
    freeze = 1'b0; freeze2 = 1'b0;
    ball_x = '0; ball_y = '0; ball_x2 = '0; ball_y2 = '0;
    video_on = 1'b0; pix_x = '0; pix_y = '0;
    step();
    check_eq("rst_brick_on", int'(brick_on), 0);
    check_eq("rst_hit", int'(hit), 0);
    check_eq("rst_taken", int'(bricks_taken), 0);
    check_eq("rst_busy", int'(scan_busy), 0);
    check_eq("rst_cleared", int'(all_cleared), 0);
    reset = 1'b1; reset2 = 1'b1;
    step();

    render(5, 35, 1'b1);
    check_eq("px_5_35_on", int'(brick_on), 1);
    check_eq("px_5_35_rgb", int'(brick_rgb), 7);
    render(5, 50, 1'b1);
    check_eq("px_5_50_rgb", int'(brick_rgb), 6);
    render(62, 35, 1'b1);
    check_eq("px_gap_on", int'(brick_on), 0);
    render(5, 35, 1'b0);
    check_eq("px_blank_on", int'(brick_on), 0);
    check_eq("px_blank_rgb", int'(brick_rgb), 0);

    ball_x = 10'd70; ball_y = 10'd36;
    run_scan(1'b0, 50, hit_at, busy, nhit);
    check_eq("b1_hit_at", hit_at, 3);
    check_eq("b1_nhit", nhit, 1);
    check_eq("b1_busy", busy, 2);
    check_eq("b1_side", int'(hit_side), 1);
    check_eq("b1_taken", int'(bricks_taken), 1);
    render(70, 36, 1'b1);
    check_eq("b1_gone", int'(brick_on), 0);

    run_scan(1'b0, 60, hit_at, busy, nhit);
    check_eq("miss_nhit", nhit, 0);
    check_eq("miss_busy", busy, 40);
    check_eq("miss_side", int'(hit_side), 0);
    check_eq("miss_taken", int'(bricks_taken), 1);

    ball_x = 10'd120; ball_y = 10'd50;
    run_scan(1'b0, 50, hit_at, busy, nhit);
    check_eq("b11_hit_at", hit_at, 13);
    check_eq("b11_nhit", nhit, 1);
    check_eq("b11_side", int'(hit_side), 2);
    check_eq("b11_taken", int'(bricks_taken), 2);

    freeze = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("frz_busy0", int'(scan_busy), 0);
    step();
    check_eq("frz_busy1", int'(scan_busy), 0);
    freeze = 1'b0;

    new_game = 1'b1; tick = 1'b1;
    step();
    new_game = 1'b0; tick = 1'b0;
    check_eq("ng_taken", int'(bricks_taken), 0);
    check_eq("ng_side", int'(hit_side), 0);
    check_eq("ng_busy", int'(scan_busy), 0);
    step();
    check_eq("ng_busy_late", int'(scan_busy), 0);
    render(70, 36, 1'b1);
    check_eq("ng_b1_back", int'(brick_on), 1);

    ball_x = 10'd70; ball_y = 10'd36;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("mid_busy", int'(scan_busy), 1);
    freeze = 1'b1;
    step();
    check_eq("mid_abort", int'(scan_busy), 0);
    check_eq("mid_hit", int'(hit), 0);
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("mid_taken", int'(bricks_taken), 0);
    render(70, 36, 1'b1);
    check_eq("mid_b1_alive", int'(brick_on), 1);
    run_scan(1'b0, 50, hit_at, busy, nhit);
    check_eq("rehit_at", hit_at, 3);
    check_eq("rehit_taken", int'(bricks_taken), 1);

    ball_x2 = 10'd10; ball_y2 = 10'd34;
    run_scan(1'b1, 10, hit_at, busy, nhit);
    check_eq("w2_b0_hit_at", hit_at, 2);
    check_eq("w2_b0_taken", int'(bricks_taken2), 1);
    check_eq("w2_b0_cleared", int'(all_cleared2), 0);
    ball_x2 = 10'd70;
    run_scan(1'b1, 10, hit_at, busy, nhit);
    check_eq("w2_b1_hit_at", hit_at, 3);
    check_eq("w2_b1_side", int'(hit_side2), 1);
    check_eq("w2_taken", int'(bricks_taken2), 2);
    check_eq("w2_cleared", int'(all_cleared2), 1);
    run_scan(1'b1, 10, hit_at, busy, nhit);
    check_eq("w2_ign_busy", busy, 0);
    check_eq("w2_ign_nhit", nhit, 0);
    check_eq("w2_ign_taken", int'(bricks_taken2), 2);
    check_eq("w2_ign_cleared", int'(all_cleared2), 1);

    new_game2 = 1'b1;
    step();
    new_game2 = 1'b0;
    check_eq("w2_ng_cleared", int'(all_cleared2), 0);
    check_eq("w2_ng_taken", int'(bricks_taken2), 0);
    run_scan(1'b1, 10, hit_at, busy, nhit);
    check_eq("w2_pre_taken", int'(bricks_taken2), 1);

    ball_x2 = 10'd10;
    tick2 = 1'b1;
    step();
    tick2 = 1'b0;
    check_eq("w2_rst_busy_pre", int'(scan_busy2), 1);
    reset2 = 1'b0;
    #1;
    check_eq("w2_rst_busy", int'(scan_busy2), 0);
    check_eq("w2_rst_taken", int'(bricks_taken2), 0);
    check_eq("w2_rst_hit", int'(hit2), 0);
    check_eq("w2_rst_side", int'(hit_side2), 0);
    check_eq("w2_rst_cleared", int'(all_cleared2), 0);
    check_eq("w2_rst_on", int'(brick_on2), 0);
    step();
    reset2 = 1'b1;
    render(70, 36, 1'b1);
    check_eq("w2_b1_restored", int'(brick_on2), 1);
    render(5, 35, 1'b1);
    check_eq("w2_b0_restored", int'(brick_on2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
